spi_reg_slave: RTL and testbench

SPI responder with a command/address/data framing and an internal register file, for connection to the existing SPI master (point-to-point or at the end of a daisy chain). It oversamples sclk, csn and mosi in the system clock domain and decodes a command byte, then one or more data bytes, from each csn-low frame. Data bytes either write the addressed register or shift its contents out on miso. The register address auto-increments for bursts. A local port lets the fabric read the registers and observe SPI writes.

---
 rtl/spi_reg_slave.sv | 153 +++++++++++++++
 tb/tb_spi_reg_slave.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_slave.sv
// SPI register-file responder: command byte (R/W + start address) then data bytes,
// with oversampled SPI pins, auto-incrementing burst pointer and a local read port.
module spi_reg_slave #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter bit                    CPOL       = 1'b0,
  parameter bit                    CPHA       = 1'b0,
  parameter logic [DATA_WIDTH-1:0] STATUS     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  sclk,
  input  logic                  csn,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  wr_strobe,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  frame_done,
  input  logic [ADDR_WIDTH-1:0] loc_addr,
  output logic [DATA_WIDTH-1:0] loc_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam bit SAMPLE_ON_RISE = ((CPOL ^ CPHA) == 1'b0);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t                state, state_nxt;
  logic [2:0]            sclk_sync;
  logic [2:0]            csn_sync;
  logic [1:0]            mosi_sync;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  rw;
  logic                  got_word;
  logic [DATA_WIDTH-1:0] regs [DEPTH];

  logic sclk_rise, sclk_fall, csn_fall, csn_rise, csn_high;
  logic sample_edge, shift_edge, active, word_done, reg_we;
  logic [DATA_WIDTH-1:0] rx_word;

  // csn synchronizer resets low so a frame already running at reset release
  // produces no falling edge until csn has gone high and low again.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sclk_sync <= {3{CPOL}};
      csn_sync  <= '0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      csn_sync  <= {csn_sync[1:0], csn};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  assign sclk_rise   = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall   = ~sclk_sync[1] & sclk_sync[2];
  assign csn_fall    = ~csn_sync[1] & csn_sync[2];
  assign csn_rise    = csn_sync[1] & ~csn_sync[2];
  assign csn_high    = csn_sync[1];
  assign sample_edge = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;
  assign active      = (state != IDLE) && !csn_high;
  assign word_done   = active && sample_edge && (bit_cnt == LAST_BIT);
  assign rx_word     = {rx_shift, mosi_sync[1]};
  assign reg_we      = word_done && (state == DATA) && !rw;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (csn_high) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (csn_fall) state_nxt = CMD;
        CMD:     if (word_done) state_nxt = DATA;
        default: state_nxt = state;
      endcase
    end
  end

  // A shift edge with no bits yet sampled in the current word starts a new
  // word on miso; this covers both phases since CPHA=0 never leads with a shift edge.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      ptr        <= '0;
      rw         <= 1'b0;
      got_word   <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_strobe  <= reg_we;
      frame_done <= csn_rise && (state != IDLE) && got_word;
      if (reg_we) begin
        wr_addr <= ptr;
        wr_data <= rx_word;
      end
      if (state == IDLE) begin
        if (csn_fall) begin
          bit_cnt  <= '0;
          tx_shift <= STATUS;
          got_word <= 1'b0;
        end
      end else if (active) begin
        if (sample_edge) begin
          rx_shift <= rx_word[DATA_WIDTH-2:0];
          bit_cnt  <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            got_word <= 1'b1;
            if (state == CMD) begin
              rw  <= rx_word[DATA_WIDTH-1];
              ptr <= rx_word[ADDR_WIDTH-1:0];
            end else begin
              ptr <= ptr + ADDR_WIDTH'(1);
            end
          end
        end
        if (shift_edge) begin
          if (bit_cnt == '0)
            tx_shift <= (state == CMD) ? STATUS : (rw ? regs[ptr] : '0);
          else
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[ptr] <= rx_word;
    end
  end

  assign miso      = (state != IDLE) ? tx_shift[DATA_WIDTH-1] : 1'b0;
  assign loc_rdata = regs[loc_addr];

endmodule

// File: tb/tb_spi_reg_slave.sv
// Self-checking bench for spi_reg_slave: one instance per CPOL/CPHA mode, directed
// frames plus randomized frames checked against an array-based register model.
module tb_spi_reg_slave;

  localparam int         HALF   = 8;
  localparam logic [7:0] STATUS = 8'hA5;

  logic            clk = 1'b0;
  logic            arstn;
  logic            csn;
  logic            mosi;
  logic [3:0]      sclk_v;
  logic [3:0]      loc_addr;
  wire  [3:0]      miso_v;
  wire  [3:0]      wr_strobe_v;
  wire  [3:0]      frame_done_v;
  wire  [3:0][3:0] wr_addr_v;
  wire  [3:0][7:0] wr_data_v;
  wire  [3:0][7:0] loc_rdata_v;

  int tests_run    = 0;
  int tests_failed = 0;
  int cur_mode     = 0;
  int strobe_cnt [4];
  int fd_cnt [4];
  logic [11:0] cap_q [$];
  logic [7:0]  tx_q [$];
  logic [7:0]  rx_q [$];
  logic [7:0]  ref_regs [4][16];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam bit P_CPOL = (g >= 2);
    localparam bit P_CPHA = ((g % 2) == 1);
    spi_reg_slave #(
      .DATA_WIDTH(8), .ADDR_WIDTH(4), .CPOL(P_CPOL), .CPHA(P_CPHA), .STATUS(8'hA5)
    ) dut (
      .clk(clk), .arstn(arstn), .sclk(sclk_v[g]), .csn(csn), .mosi(mosi),
      .miso(miso_v[g]), .wr_strobe(wr_strobe_v[g]), .wr_addr(wr_addr_v[g]),
      .wr_data(wr_data_v[g]), .frame_done(frame_done_v[g]),
      .loc_addr(loc_addr), .loc_rdata(loc_rdata_v[g])
    );
  end

  // Pulse monitor, sampled mid-cycle so each one-clk pulse is seen exactly once.
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (wr_strobe_v[g]) begin
        strobe_cnt[g]++;
        if (g == cur_mode) cap_q.push_back({wr_addr_v[g], wr_data_v[g]});
      end
      if (frame_done_v[g]) fd_cnt[g]++;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    cap_q.delete();
    for (int g = 0; g < 4; g++) begin
      strobe_cnt[g] = 0;
      fd_cnt[g] = 0;
    end
  endtask

  task automatic clear_model();
    for (int g = 0; g < 4; g++)
      for (int a = 0; a < 16; a++) ref_regs[g][a] = 8'h00;
  endtask

  task automatic check_regs(input int m);
    for (int a = 0; a < 16; a++) begin
      loc_addr = 4'(a);
      #1;
      check_output($sformatf("m%0d reg[%0d]", m, a), 32'(loc_rdata_v[m]), 32'(ref_regs[m][a]));
    end
  endtask

  // Plays tx_q as a master in mode m; abort_bits>0 cuts the last byte short.
  task automatic apply_stimulus(input int m, input int abort_bits);
    bit cpol, cpha;
    logic [7:0] b, r;
    int nbits;
    cpol = m[1];
    cpha = m[0];
    rx_q.delete();
    cur_mode = m;
    csn = 1'b0;
    for (int i = 0; i < tx_q.size(); i++) begin
      b = tx_q[i];
      r = 8'h00;
      nbits = (abort_bits > 0 && i == tx_q.size() - 1) ? abort_bits : 8;
      for (int k = 7; k >= 8 - nbits; k--) begin
        if (!cpha) begin
          mosi = b[k];
          wait_clk(HALF);
          sclk_v[m] = ~cpol;
          r[k] = miso_v[m];
          wait_clk(HALF);
          sclk_v[m] = cpol;
        end else begin
          wait_clk(HALF);
          sclk_v[m] = ~cpol;
          mosi = b[k];
          wait_clk(HALF);
          sclk_v[m] = cpol;
          r[k] = miso_v[m];
        end
      end
      rx_q.push_back(r);
    end
    wait_clk(HALF);
    csn = 1'b1;
    wait_clk(12);
  endtask

  // Model: status byte first, then each complete data byte reads or writes
  // reg[ptr] with ptr advancing modulo 16; a partial last byte has no effect.
  task automatic run_frame(input int m, input int abort_bits);
    logic [7:0]  exp_rx [$];
    bit          chk_rx [$];
    logic [11:0] exp_wr [$];
    int n_full, ptr, others;
    bit rw;
    n_full = (abort_bits > 0) ? tx_q.size() - 1 : tx_q.size();
    rw  = tx_q[0][7];
    ptr = int'(tx_q[0] & 8'h0F);
    exp_rx.push_back(STATUS);
    chk_rx.push_back(1'b1);
    for (int i = 1; i < n_full; i++) begin
      if (rw) begin
        exp_rx.push_back(ref_regs[m][ptr]);
        chk_rx.push_back(1'b1);
      end else begin
        exp_rx.push_back(8'h00);
        chk_rx.push_back(1'b0);
        exp_wr.push_back({ptr[3:0], tx_q[i]});
        ref_regs[m][ptr] = tx_q[i];
      end
      ptr = (ptr + 1) % 16;
    end
    clear_counts();
    apply_stimulus(m, abort_bits);
    for (int i = 0; i < n_full; i++)
      if (chk_rx[i]) check_output($sformatf("m%0d rx[%0d]", m, i), 32'(rx_q[i]), 32'(exp_rx[i]));
    check_output($sformatf("m%0d wr_strobe count", m), 32'(strobe_cnt[m]), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < cap_q.size(); i++)
      check_output($sformatf("m%0d write[%0d] addr/data", m, i), 32'(cap_q[i]), 32'(exp_wr[i]));
    check_output($sformatf("m%0d frame_done count", m), 32'(fd_cnt[m]), (n_full >= 1) ? 32'd1 : 32'd0);
    others = 0;
    for (int g = 0; g < 4; g++) if (g != m) others += strobe_cnt[g] + fd_cnt[g];
    check_output($sformatf("m%0d idle instances quiet", m), 32'(others), 32'd0);
    check_regs(m);
  endtask

  task automatic check_idle_outputs(input string tag, input int m);
    check_output(tag, {miso_v[m], wr_strobe_v[m], frame_done_v[m], wr_addr_v[m], wr_data_v[m]}, 32'd0);
  endtask

  initial begin
    arstn    = 1'b0;
    csn      = 1'b1;
    mosi     = 1'b0;
    sclk_v   = 4'b1100;
    loc_addr = 4'd0;
    clear_model();
    clear_counts();
    wait_clk(4);
    for (int g = 0; g < 4; g++) check_idle_outputs($sformatf("m%0d reset outputs", g), g);
    check_regs(0);
    arstn = 1'b1;
    wait_clk(5);

    tx_q = '{8'h03, 8'h5C};
    run_frame(0, 0);

    for (int m = 0; m < 4; m++) begin
      tx_q = '{8'h07, 8'hC3};
      run_frame(m, 0);
      tx_q = '{8'h87, 8'h00};
      run_frame(m, 0);
    end

    tx_q = '{8'h0E, 8'h11, 8'h22, 8'h33};
    run_frame(0, 0);

    tx_q = '{8'h01, 8'hAA, 8'hBB};
    run_frame(1, 0);
    tx_q = '{8'h81, 8'h00, 8'h00};
    run_frame(1, 0);

    tx_q = '{8'h04, 8'hFF};
    run_frame(0, 5);
    tx_q = '{8'h04, 8'h12};
    run_frame(0, 0);

    for (int n = 0; n < 30; n++) begin
      int m, len, cut;
      m   = $urandom_range(0, 3);
      len = $urandom_range(1, 4);
      tx_q.delete();
      tx_q.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom_range(0, 255)));
      cut = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
      run_frame(m, cut);
    end

    // Reset in the middle of a write burst; the remainder of that frame must be ignored.
    clear_counts();
    tx_q = '{8'h02, 8'h77, 8'h66, 8'h55, 8'h44};
    fork
      apply_stimulus(0, 0);
      begin
        wait_clk(HALF + 16 * 8 + 16 * 3);
        arstn = 1'b0;
        wait_clk(3);
        clear_model();
        check_idle_outputs("m0 mid-frame reset outputs", 0);
        check_regs(0);
        wait_clk(2);
        arstn = 1'b1;
        clear_counts();
      end
    join
    check_output("m0 post-reset wr_strobe count", 32'(strobe_cnt[0]), 32'd0);
    check_output("m0 post-reset frame_done count", 32'(fd_cnt[0]), 32'd0);
    check_regs(0);
    tx_q = '{8'h05, 8'h9A};
    run_frame(0, 0);
    tx_q = '{8'h85, 8'h00};
    run_frame(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
